// File: rtl/scratch_pad_port_arbiter_pkg.sv
// rtl/scratch_pad_port_arbiter_pkg.sv - shared types and sizing helpers for the scratch pad port arbiter
package scratch_pad_port_arbiter_pkg;

  // Operation issued to the scratch pad port in a given cycle
  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } sp_op_e;

  // Ceiling log2, never below 1 so that derived vectors stay legal
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/arbiter_tag_fifo.sv
// rtl/arbiter_tag_fifo.sv - in-order FIFO of requester IDs for outstanding reads
module arbiter_tag_fifo
  import scratch_pad_port_arbiter_pkg::*;
#(
  parameter int TAG_WIDTH = 2,
  parameter int DEPTH     = 32,
  parameter int CNT_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [TAG_WIDTH-1:0] din,
  output logic [TAG_WIDTH-1:0] head,
  output logic [CNT_WIDTH-1:0] count
);

  localparam int PTR_WIDTH = clog2_min1(DEPTH);

  logic [TAG_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_WIDTH'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Guard against popping an empty FIFO or pushing into a full one without a matching pop
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != CNT_WIDTH'(DEPTH)) || do_pop);
  end

  // First-word-fall-through: the oldest tag is always visible
  assign head = mem[rd_ptr];

  // Circular pointers and occupancy; a simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/scratch_pad_port_arbiter.sv
// rtl/scratch_pad_port_arbiter.sv - round-robin sharing of one scratch_pad port with read response steering
module scratch_pad_port_arbiter
  import scratch_pad_port_arbiter_pkg::*;
#(
  parameter int REQUESTERS  = 4,
  parameter int WIDTH       = 64,
  parameter int ADDR_WIDTH  = 12,
  parameter int OUTSTANDING = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [REQUESTERS-1:0]            req_rd,
  input  logic [REQUESTERS-1:0]            req_wr,
  input  logic [REQUESTERS*ADDR_WIDTH-1:0] req_addr,
  input  logic [REQUESTERS*WIDTH-1:0]      req_d,
  output logic [REQUESTERS-1:0]            gnt,
  output logic [WIDTH-1:0]                 resp_q,
  output logic [REQUESTERS-1:0]            resp_valid,
  input  logic [REQUESTERS-1:0]            resp_stall,
  output logic                             err,
  output logic                             sp_rd_en,
  output logic                             sp_wr_en,
  output logic [ADDR_WIDTH-1:0]            sp_addr,
  output logic [WIDTH-1:0]                 sp_d,
  input  logic [WIDTH-1:0]                 sp_q,
  input  logic                             sp_valid,
  input  logic                             sp_full,
  output logic                             sp_stall
);

  localparam int TAG_WIDTH = clog2_min1(REQUESTERS);
  localparam int CNT_WIDTH = clog2_min1(OUTSTANDING) + 1;

  logic [TAG_WIDTH-1:0]  rr_ptr;
  logic [TAG_WIDTH-1:0]  win;
  logic                  found;
  sp_op_e                win_op;
  logic [REQUESTERS-1:0] cand;
  logic                  read_blocked;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0]      sel_d;
  logic [TAG_WIDTH-1:0]  head_tag;
  logic [CNT_WIDTH-1:0]  tag_count;
  logic                  fifo_empty;
  logic                  tag_push;
  logic                  tag_pop;

  // Candidate set: eligible clients minus reads that would overflow the tag FIFO
  always_comb begin
    read_blocked = (tag_count == CNT_WIDTH'(OUTSTANDING));
    cand = (req_rd | req_wr) & ~(req_rd & {REQUESTERS{read_blocked}});
    if (sp_full || !rst) cand = '0;
  end

  // Round-robin pick: smallest distance from the slot after the last winner
  always_comb begin
    int best_d;
    int d;
    best_d = REQUESTERS;
    d      = 0;
    win    = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (cand[i]) begin
        d = (i + REQUESTERS - 1 - int'(rr_ptr)) % REQUESTERS;
        if (d < best_d) begin
          best_d = d;
          win    = TAG_WIDTH'(i);
        end
      end
    end
    found = (best_d < REQUESTERS);
  end

  // One-hot grant, operation type and the winner's address/data
  always_comb begin
    gnt      = '0;
    win_op   = OP_NONE;
    sel_addr = '0;
    sel_d    = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (found && (win == TAG_WIDTH'(i))) begin
        gnt[i]   = 1'b1;
        win_op   = req_rd[i] ? OP_READ : OP_WRITE;
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_d    = req_d[i*WIDTH +: WIDTH];
      end
    end
  end

  assign tag_push = (win_op == OP_READ);

  // Steer returned data to the client whose tag is oldest; nothing is routed when no read is pending
  always_comb begin
    resp_valid = '0;
    sp_stall   = 1'b0;
    if (!fifo_empty) begin
      resp_valid[head_tag] = sp_valid;
      sp_stall             = resp_stall[head_tag];
    end
  end

  assign resp_q     = sp_q;
  assign fifo_empty = (tag_count == '0);
  assign tag_pop    = sp_valid && !sp_stall && !fifo_empty;

  // Port registers and RR pointer; address/data hold when nothing is granted
  always_ff @(posedge clk) begin
    if (!rst) begin
      sp_rd_en <= 1'b0;
      sp_wr_en <= 1'b0;
      sp_addr  <= '0;
      sp_d     <= '0;
      rr_ptr   <= TAG_WIDTH'(REQUESTERS - 1);
    end else begin
      sp_rd_en <= (win_op == OP_READ);
      sp_wr_en <= (win_op == OP_WRITE);
      if (win_op != OP_NONE) begin
        sp_addr <= sel_addr;
        sp_d    <= sel_d;
        rr_ptr  <= win;
      end
    end
  end

  // Sticky error on simultaneous read+write requests or on a response with no read pending
  always_ff @(posedge clk) begin
    if (!rst) begin
      err <= 1'b0;
    end else if ((|(req_rd & req_wr)) || (sp_valid && fifo_empty)) begin
      err <= 1'b1;
    end
  end

  arbiter_tag_fifo #(
    .TAG_WIDTH (TAG_WIDTH),
    .DEPTH     (OUTSTANDING),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tag_push),
    .pop   (tag_pop),
    .din   (win),
    .head  (head_tag),
    .count (tag_count)
  );

endmodule

// File: tb/tb_scratch_pad_port_arbiter.sv
// tb/tb_scratch_pad_port_arbiter.sv - directed self-checking bench for scratch_pad_port_arbiter
module tb_scratch_pad_port_arbiter;

  localparam int R  = 4;
  localparam int W  = 64;
  localparam int AW = 12;

  logic            clk;
  logic            rst;
  logic [R-1:0]    req_rd;
  logic [R-1:0]    req_wr;
  logic [R*AW-1:0] req_addr;
  logic [R*W-1:0]  req_d;
  logic [R-1:0]    gnt;
  logic [W-1:0]    resp_q;
  logic [R-1:0]    resp_valid;
  logic [R-1:0]    resp_stall;
  logic            err;
  logic            sp_rd_en;
  logic            sp_wr_en;
  logic [AW-1:0]   sp_addr;
  logic [W-1:0]    sp_d;
  logic [W-1:0]    sp_q;
  logic            sp_valid;
  logic            sp_full;
  logic            sp_stall;

  int passed;
  int total;

  scratch_pad_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_rd     (req_rd),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_d      (req_d),
    .gnt        (gnt),
    .resp_q     (resp_q),
    .resp_valid (resp_valid),
    .resp_stall (resp_stall),
    .err        (err),
    .sp_rd_en   (sp_rd_en),
    .sp_wr_en   (sp_wr_en),
    .sp_addr    (sp_addr),
    .sp_d       (sp_d),
    .sp_q       (sp_q),
    .sp_valid   (sp_valid),
    .sp_full    (sp_full),
    .sp_stall   (sp_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [3:0] fair_exp [5];

  initial begin
    passed = 0;
    total  = 0;
    fair_exp[0] = 4'b0001;
    fair_exp[1] = 4'b0010;
    fair_exp[2] = 4'b0100;
    fair_exp[3] = 4'b1000;
    fair_exp[4] = 4'b0001;

    rst        = 1'b0;
    req_rd     = '0;
    req_wr     = '0;
    resp_stall = '0;
    sp_q       = '0;
    sp_valid   = 1'b0;
    sp_full    = 1'b0;
    for (int i = 0; i < R; i++) begin
      req_addr[i*AW +: AW] = 12'h100 + 12'(i);
      req_d[i*W +: W]      = 64'hD0 + 64'(i);
    end

    // Reset held 3 cycles with every client requesting
    req_wr = 4'hF;
    repeat (3) begin
      tick();
      #1;
      chk("reset_gnt", 64'(gnt), 64'h0);
    end
    chk("reset_sp_rd_en", 64'(sp_rd_en), 64'h0);
    chk("reset_sp_wr_en", 64'(sp_wr_en), 64'h0);
    chk("reset_sp_addr", 64'(sp_addr), 64'h0);
    chk("reset_sp_d", sp_d, 64'h0);
    chk("reset_err", 64'(err), 64'h0);
    chk("reset_resp_valid", 64'(resp_valid), 64'h0);
    chk("reset_sp_stall", 64'(sp_stall), 64'h0);

    // Fairness: rotating grants, sp_addr trails the winner by one cycle
    rst = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("fair_gnt", 64'(gnt), 64'(fair_exp[k]));
      if (k > 0) begin
        chk("fair_sp_addr", 64'(sp_addr), 64'h100 + 64'((k - 1) % R));
        chk("fair_sp_wr_en", 64'(sp_wr_en), 64'h1);
      end
      tick();
      #1;
    end
    chk("fair_last_addr", 64'(sp_addr), 64'h100);
    chk("fair_last_d", sp_d, 64'hD0);

    // sp_full blocks issue for exactly its 4 cycles; RR order resumes from client 1
    sp_full = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("full_gnt", 64'(gnt), 64'h0);
      tick();
      #1;
      chk("full_sp_wr_en", 64'(sp_wr_en), 64'h0);
    end
    sp_full = 1'b0;
    #1;
    chk("full_resume_gnt0", 64'(gnt), 64'b0010);
    tick();
    #1;
    chk("full_resume_addr", 64'(sp_addr), 64'h101);
    chk("full_resume_gnt1", 64'(gnt), 64'b0100);
    tick();
    req_wr = '0;
    #1;

    // Read routing: client 2 reads addr 5, then client 1 reads addr 9
    req_addr[2*AW +: AW] = 12'd5;
    req_addr[1*AW +: AW] = 12'd9;
    req_rd = 4'b0100;
    #1;
    chk("rd_gnt_c2", 64'(gnt), 64'b0100);
    tick();
    req_rd = 4'b0010;
    #1;
    chk("rd_sp_rd_en_c2", 64'(sp_rd_en), 64'h1);
    chk("rd_sp_addr_c2", 64'(sp_addr), 64'd5);
    chk("rd_gnt_c1", 64'(gnt), 64'b0010);
    tick();
    req_rd = '0;
    #1;
    chk("rd_sp_addr_c1", 64'(sp_addr), 64'd9);
    resp_stall = 4'b0100;
    #1;
    chk("rd_stall_follows_c2", 64'(sp_stall), 64'h1);
    chk("rd_no_valid", 64'(resp_valid), 64'h0);
    sp_valid = 1'b1;
    sp_q     = 64'hAA;
    #1;
    chk("rd_valid_c2", 64'(resp_valid), 64'b0100);
    chk("rd_resp_q_c2", resp_q, 64'hAA);
    tick();
    #1;
    chk("rd_valid_c2_stalled", 64'(resp_valid), 64'b0100);
    resp_stall = 4'b0000;
    #1;
    chk("rd_stall_release", 64'(sp_stall), 64'h0);
    tick();
    sp_q       = 64'hBB;
    resp_stall = 4'b0100;
    #1;
    chk("rd_valid_c1", 64'(resp_valid), 64'b0010);
    chk("rd_stall_c1_head", 64'(sp_stall), 64'h0);
    chk("rd_resp_q_c1", resp_q, 64'hBB);
    tick();
    sp_valid   = 1'b0;
    resp_stall = 4'hF;
    #1;
    chk("rd_empty_valid", 64'(resp_valid), 64'h0);
    chk("rd_empty_stall", 64'(sp_stall), 64'h0);
    chk("rd_no_err", 64'(err), 64'h0);
    resp_stall = '0;

    // Outstanding limit: 32 reads from client 0 with no returns
    req_addr[0*AW +: AW] = 12'h020;
    req_rd = 4'b0001;
    #1;
    for (int k = 0; k < 32; k++) begin
      chk("out_fill_gnt", 64'(gnt), 64'b0001);
      tick();
      #1;
    end
    req_wr = 4'b1000;
    #1;
    chk("out_full_write_wins", 64'(gnt), 64'b1000);
    tick();
    req_wr = '0;
    #1;
    chk("out_write_issued", 64'(sp_wr_en), 64'h1);
    chk("out_write_addr", 64'(sp_addr), 64'h103);
    chk("out_read_blocked", 64'(gnt), 64'h0);
    sp_valid = 1'b1;
    #1;
    chk("out_blocked_during_pop", 64'(gnt), 64'h0);
    tick();
    sp_valid = 1'b0;
    #1;
    chk("out_granted_after_pop", 64'(gnt), 64'b0001);
    tick();
    req_rd = '0;
    #1;
    chk("out_read_addr", 64'(sp_addr), 64'h020);

    // Error: simultaneous read and write from client 1 is served as a read
    rst = 1'b0;
    tick();
    #1;
    chk("err_reset_clear", 64'(err), 64'h0);
    chk("err_reset_rd_en", 64'(sp_rd_en), 64'h0);
    rst    = 1'b1;
    req_rd = 4'b0010;
    req_wr = 4'b0010;
    #1;
    chk("err_both_gnt", 64'(gnt), 64'b0010);
    tick();
    req_rd = '0;
    req_wr = '0;
    #1;
    chk("err_both_as_read", 64'(sp_rd_en), 64'h1);
    chk("err_both_no_write", 64'(sp_wr_en), 64'h0);
    chk("err_both_set", 64'(err), 64'h1);
    tick();
    #1;
    chk("err_both_sticky", 64'(err), 64'h1);

    // Error: response with no read outstanding
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("err_cleared", 64'(err), 64'h0);
    sp_valid = 1'b1;
    #1;
    chk("err_orphan_dropped", 64'(resp_valid), 64'h0);
    tick();
    sp_valid = 1'b0;
    #1;
    chk("err_orphan_set", 64'(err), 64'h1);
    repeat (3) tick();
    #1;
    chk("err_orphan_sticky", 64'(err), 64'h1);
    rst = 1'b0;
    tick();
    #1;
    chk("err_final_reset", 64'(err), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
